// File: rtl/alu_wide_seq.sv
// alu_wide_seq: sequences an external 8-bit combinational ALU to run 16-bit ADD/SUB/CMP and 8x8 MUL.
//   in : clk, reset (sync, active-high), start, op[1:0], opa[15:0], opb[15:0], alu_rslt[7:0], alu_sco
//   out: busy, done, result[15:0], carry_o, zero_o, alu_type[1:0], alu_mop[2:0], alu_ina[7:0], alu_inb[7:0], alu_sci
module alu_wide_seq #(
  parameter int         W         = 8,
  parameter logic [1:0] TYPE_MATH = 2'b00,
  parameter logic [2:0] MOP_ADD   = 3'b000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [2*W-1:0]   opa,
  input  logic [2*W-1:0]   opb,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   result,
  output logic             carry_o,
  output logic             zero_o,
  output logic [1:0]       alu_type,
  output logic [2:0]       alu_mop,
  output logic [W-1:0]     alu_ina,
  output logic [W-1:0]     alu_inb,
  output logic             alu_sci,
  input  logic [W-1:0]     alu_rslt,
  input  logic             alu_sco
);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_CMP = 2'b11;
  typedef enum logic [2:0] {IDLE, LO, HI, MUL, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [2*W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
  logic [2:0] cnt_q, cnt_d;
  logic [W-1:0] lo_q, lo_d;
  logic c_q, c_d, carry_q, carry_d, zero_q, zero_d;
  logic sub, issue;
  // SUB and CMP both run as A + ~B + 1
  assign sub      = op_q != OP_ADD;
  assign issue    = state_q == LO || state_q == HI || state_q == MUL;
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign result   = result_q;
  assign carry_o  = carry_q;
  assign zero_o   = zero_q;
  assign alu_type = issue ? TYPE_MATH : '0;
  assign alu_mop  = issue ? MOP_ADD : '0;
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    lo_d     = lo_q;
    c_d      = c_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    alu_ina  = '0;
    alu_inb  = '0;
    alu_sci  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        op_d    = op;
        a_d     = opa;
        b_d     = opb;
        acc_d   = {{W{1'b0}}, opb[W-1:0]};
        cnt_d   = '0;
        state_d = op == OP_MUL ? MUL : LO;
      end
      LO: begin
        alu_ina = a_q[W-1:0];
        alu_inb = sub ? ~b_q[W-1:0] : b_q[W-1:0];
        alu_sci = sub;
        lo_d    = alu_rslt;
        c_d     = alu_sco;
        state_d = HI;
      end
      HI: begin
        alu_ina  = a_q[2*W-1:W];
        alu_inb  = sub ? ~b_q[2*W-1:W] : b_q[2*W-1:W];
        alu_sci  = c_q;
        carry_d  = alu_sco;
        zero_d   = {alu_rslt, lo_q} == '0;
        result_d = op_q == OP_CMP ? result_q : {alu_rslt, lo_q};
        state_d  = DONE;
      end
      MUL: begin
        // shift-add: add multiplicand into the high half when the low bit is set, then shift the 17-bit sum right
        alu_ina = acc_q[2*W-1:W];
        alu_inb = acc_q[0] ? a_q[W-1:0] : '0;
        acc_d   = {alu_sco, alu_rslt, acc_q[W-1:1]};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'(W-1)) begin
          result_d = acc_d;
          carry_d  = 1'b0;
          zero_d   = acc_d == '0;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      lo_q     <= '0;
      c_q      <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      lo_q     <= lo_d;
      c_q      <= c_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end
endmodule

// File: tb/tb_alu_wide_seq.sv
// tb_alu_wide_seq: directed self-checking bench for alu_wide_seq with a behavioural 8-bit ALU.
module tb_alu_wide_seq;
  logic clk = 1'b0;
  logic reset, start, busy, done, carry_o, zero_o, alu_sci, alu_sco;
  logic [1:0] op, alu_type;
  logic [2:0] alu_mop;
  logic [15:0] opa, opb, result;
  logic [7:0] alu_ina, alu_inb, alu_rslt;
  int tests_run = 0;
  int failed = 0;
  int lat, busy_n;
  logic [7:0] lo_ina, lo_inb;
  logic lo_sci;
  always #5 clk = ~clk;
  assign {alu_sco, alu_rslt} = (alu_type == 2'b00 && alu_mop == 3'b000) ?
                               {1'b0, alu_ina} + {1'b0, alu_inb} + {8'h00, alu_sci} : 9'h000;
  alu_wide_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result), .carry_o(carry_o), .zero_o(zero_o),
    .alu_type(alu_type), .alu_mop(alu_mop), .alu_ina(alu_ina), .alu_inb(alu_inb),
    .alu_sci(alu_sci), .alu_rslt(alu_rslt), .alu_sco(alu_sco)
  );
  task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    lat = -1; busy_n = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 1) begin lo_ina = alu_ina; lo_inb = alu_inb; lo_sci = alu_sci; end
      if (busy) busy_n++;
      if (done) begin lat = n; break; end
    end
  endtask
  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 2'b00; opa = '0; opb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin failed++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    tests_run++; if (result !== 16'h0000 || carry_o !== 1'b0 || zero_o !== 1'b0) begin failed++; $display("FAIL reset_result got=%h c=%b z=%b exp=0000 c=0 z=0", result, carry_o, zero_o); end
    tests_run++; if ({alu_type, alu_mop, alu_ina, alu_inb, alu_sci} !== 22'h0) begin failed++; $display("FAIL reset_alu got=%h exp=0", {alu_type, alu_mop, alu_ina, alu_inb, alu_sci}); end
    reset = 1'b0;
  endtask
  task automatic test_add;
    do_op(2'b00, 16'h12FF, 16'h0001);
    tests_run++; if (lat !== 3) begin failed++; $display("FAIL add_latency got=%0d exp=3", lat); end
    tests_run++; if (busy_n !== 3) begin failed++; $display("FAIL add_busy_cycles got=%0d exp=3", busy_n); end
    tests_run++; if (result !== 16'h1300) begin failed++; $display("FAIL add_result got=%h exp=1300", result); end
    tests_run++; if (carry_o !== 1'b0 || zero_o !== 1'b0) begin failed++; $display("FAIL add_flags got c=%b z=%b exp c=0 z=0", carry_o, zero_o); end
    tests_run++; if (lo_ina !== 8'hFF || lo_inb !== 8'h01 || lo_sci !== 1'b0) begin failed++; $display("FAIL add_lo_issue got=%h %h %b exp=ff 01 0", lo_ina, lo_inb, lo_sci); end
  endtask
  task automatic test_sub;
    do_op(2'b01, 16'h0000, 16'h0001);
    tests_run++; if (result !== 16'hFFFF || carry_o !== 1'b0 || zero_o !== 1'b0) begin failed++; $display("FAIL sub_borrow got=%h c=%b z=%b exp=ffff c=0 z=0", result, carry_o, zero_o); end
    do_op(2'b01, 16'h8000, 16'h0001);
    tests_run++; if (result !== 16'h7FFF || carry_o !== 1'b1) begin failed++; $display("FAIL sub_noborrow got=%h c=%b exp=7fff c=1", result, carry_o); end
    tests_run++; if (lo_ina !== 8'h00 || lo_inb !== 8'hFE || lo_sci !== 1'b1) begin failed++; $display("FAIL sub_lo_issue got=%h %h %b exp=00 fe 1", lo_ina, lo_inb, lo_sci); end
    tests_run++; if (lat !== 3) begin failed++; $display("FAIL sub_latency got=%0d exp=3", lat); end
  endtask
  task automatic test_mul;
    do_op(2'b10, 16'h00FF, 16'h00FF);
    tests_run++; if (lat !== 9) begin failed++; $display("FAIL mul_latency got=%0d exp=9", lat); end
    tests_run++; if (result !== 16'hFE01 || carry_o !== 1'b0 || zero_o !== 1'b0) begin failed++; $display("FAIL mul_ff got=%h c=%b z=%b exp=fe01 c=0 z=0", result, carry_o, zero_o); end
    do_op(2'b10, 16'h0000, 16'h005A);
    tests_run++; if (result !== 16'h0000 || zero_o !== 1'b1) begin failed++; $display("FAIL mul_zero got=%h z=%b exp=0000 z=1", result, zero_o); end
    do_op(2'b10, 16'hAB0D, 16'hCD0B);
    tests_run++; if (result !== 16'h008F || zero_o !== 1'b0) begin failed++; $display("FAIL mul_0d_0b got=%h z=%b exp=008f z=0", result, zero_o); end
  endtask
  task automatic test_cmp;
    do_op(2'b00, 16'h12FF, 16'h0001);
    do_op(2'b11, 16'h1234, 16'h1234);
    tests_run++; if (zero_o !== 1'b1 || carry_o !== 1'b1) begin failed++; $display("FAIL cmp_equal_flags got z=%b c=%b exp z=1 c=1", zero_o, carry_o); end
    tests_run++; if (result !== 16'h1300) begin failed++; $display("FAIL cmp_equal_result got=%h exp=1300", result); end
    do_op(2'b11, 16'h0001, 16'h0002);
    tests_run++; if (zero_o !== 1'b0 || carry_o !== 1'b0 || result !== 16'h1300) begin failed++; $display("FAIL cmp_less got=%h z=%b c=%b exp=1300 z=0 c=0", result, zero_o, carry_o); end
  endtask
  task automatic test_back_to_back;
    int dn;
    dn = 0;
    @(negedge clk);
    start = 1'b1; op = 2'b00; opa = 16'h0001; opb = 16'h0002;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      if (done) dn++;
    end
    opa = 16'h0155; opb = 16'h0233;
    @(negedge clk);
    tests_run++; if (dn !== 1 || result !== 16'h0003) begin failed++; $display("FAIL b2b_first got dones=%0d result=%h exp 1 0003", dn, result); end
    tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin failed++; $display("FAIL b2b_idle_gap got busy=%b done=%b exp 0 0", busy, done); end
    tests_run++; if ({alu_type, alu_mop, alu_ina, alu_inb, alu_sci} !== 22'h0) begin failed++; $display("FAIL b2b_idle_alu got=%h exp=0", {alu_type, alu_mop, alu_ina, alu_inb, alu_sci}); end
    @(negedge clk);
    start = 1'b0;
    tests_run++; if (busy !== 1'b1 || alu_ina !== 8'h55 || alu_inb !== 8'h33 || alu_sci !== 1'b0) begin failed++; $display("FAIL b2b_second_accept got busy=%b ina=%h inb=%h sci=%b exp 1 55 33 0", busy, alu_ina, alu_inb, alu_sci); end
    lat = -1;
    for (int n = 2; n <= 10; n++) begin
      @(negedge clk);
      if (done) begin lat = n; break; end
    end
    tests_run++; if (lat !== 3 || result !== 16'h0388) begin failed++; $display("FAIL b2b_second got lat=%0d result=%h exp 3 0388", lat, result); end
  endtask
  task automatic test_reset_mid_mul;
    int dn;
    dn = 0;
    @(negedge clk);
    start = 1'b1; op = 2'b10; opa = 16'h000D; opb = 16'h000B;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin failed++; $display("FAIL rst_mid_busy got busy=%b done=%b exp 0 0", busy, done); end
    tests_run++; if (result !== 16'h0000 || carry_o !== 1'b0 || zero_o !== 1'b0) begin failed++; $display("FAIL rst_mid_result got=%h c=%b z=%b exp 0000 0 0", result, carry_o, zero_o); end
    reset = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done) dn++;
    end
    tests_run++; if (dn !== 0) begin failed++; $display("FAIL rst_mid_no_done got=%0d exp=0", dn); end
    do_op(2'b00, 16'h00FF, 16'h0001);
    tests_run++; if (lat !== 3 || result !== 16'h0100 || carry_o !== 1'b0) begin failed++; $display("FAIL rst_then_add got lat=%0d result=%h c=%b exp 3 0100 0", lat, result, carry_o); end
  endtask
  initial begin
    test_reset;
    test_add;
    test_sub;
    test_mul;
    test_cmp;
    test_back_to_back;
    test_reset_mid_mul;
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
